bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential (shift-add-3 / double-dabble) binary-to-BCD converter.
//  Sits between the LFSR random-number stage and the hex_to_7seg digit drivers.
//  Converts one W-bit unsigned value per request, one bit per clock.
//  Signals completion with a start/busy/done handshake and holds the last result
//  stable for the displays.
// PARAMETERS
//  W       16  binary input width (bits)
//  DIGITS   5  number of BCD output digits; must satisfy 10^DIGITS > 2^W-1
// PORTS
//  clk      in   1           system clock, rising-edge
//  rst_n    in   1           asynchronous active-low reset
//  start    in   1           conversion request, sampled on clk rising edge
//  bin_in   in   W           unsigned binary value, latched when start accepted
//  busy     out  1           high while a conversion is in progress
//  done     out  1           one-cycle pulse: bcd_out has just been updated
//  bcd_out  out  4*DIGITS    packed BCD result; [3:0]=ones, [7:4]=tens, ...
// BEHAVIOUR
//  Interface timing
//  - One clock domain. rst_n is asynchronous active-low: asserting it forces
//    state=IDLE, busy=0, done=0, bcd_out=0 and clears all internal registers.
//  Reset and ordinary operation
//  - Reset mid-conversion aborts the conversion. No done pulse is produced.
//  - The next start after reset release is accepted normally.
//  FSM states
//  - IDLE: busy=0.
//    - start=1 on edge E0: latch bin_in into shift reg, clear BCD scratch,
//      load bit counter=W, go to SHIFT.
//  - SHIFT: busy=1. On each edge E1..EW:
//    - every scratch digit >=5 gets +3;
//    - then {scratch, shift reg} shifts left 1, bringing in the binary MSB;
//    - counter decrements by 1.
//  - Final shift (edge EW): write the finished value into bcd_out, set done=1,
//    go to IDLE. The add-3/shift result feeds bcd_out directly, with no extra cycle.
//  Latency and handshake
//  - Latency: done is high in the cycle after edge EW, i.e. exactly W cycles
//    after the accepting edge. busy is high for cycles E0+..EW.
//  - done is a single-cycle pulse. busy=0 whenever done=1.
//  - start while busy=1 is ignored. It is neither queued nor does it restart.
//  - start high in the done cycle is accepted: back-to-back conversions run
//    every W+1 cycles.
//  - bin_in changes after acceptance have no effect.
//  - bcd_out holds the previous result for the whole conversion and changes only
//    on the done edge, so displays never show partial values.
//  Arithmetic and width
//  - Digits are 4-bit, values 0..9. The add-3 is performed only on digits >=5,
//    before each shift.
//  - Unused high digits read 0 (e.g. 127 -> 20'h00127).
//  - Configurations violating the DIGITS rule are unsupported. Upper digits then
//    truncate, and no flag is raised.
//  - W=7, DIGITS=3 is a legal configuration, for direct use with a 7-bit LFSR.
// TESTING
//  1. Reset: rst_n=0 asynchronously mid-cycle -> busy=0, done=0, bcd_out=20'h00000
//     immediately, without waiting for a clock edge.
//  2. Value range: bin_in=16'd65535, start 1 cycle -> busy for 16 cycles, then
//     done pulse with bcd_out=20'h65535. Repeat with bin_in=0 -> 20'h00000 and
//     bin_in=127 -> 20'h00127.
//  3. Start held high: start held high continuously and bin_in changed to 9999
//     after acceptance -> first result is the latched value; done pulses every
//     17 cycles; the second result is 20'h09999.
//  4. Reset mid-conversion: rst_n pulsed low at the 8th SHIFT cycle of
//     bin_in=4321 -> no done pulse, bcd_out=0. A new start with 4321 then
//     yields 20'h04321 after 16 cycles.
//  5. Random regression: 1000 random bin_in values, random idle gaps between
//     starts -> every bcd_out matches the reference decimal model; done exactly 16
//     cycles after each accepted start; bcd_out stable between done pulses.
//  6. W=7/DIGITS=3 build: every input 0..127 -> matching 3-digit BCD with
//     done after 7 cycles; 127 -> 12'h127.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq_if
//  Brief    : Start/busy/done handshake bundle for the sequential BCD converter.
//  Revision : 1.0
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) ();
    logic                  start;
    logic [W-1:0]          bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Brief    : Double-dabble binary-to-BCD converter, one input bit per clock.
//  Revision : 1.0
// ============================================================================
module bin2bcd_seq #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    bin2bcd_seq_if.slave   bus
);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(W + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [W-1:0]       r_shift;
    logic [c_BCD_W-1:0] r_scratch;
    logic [c_BCD_W-1:0] r_bcd_out;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;

    logic [c_BCD_W-1:0] w_adj;
    logic [c_BCD_W-1:0] w_next_scratch;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5)
                                   ? r_scratch[4*d +: 4] + 4'd3
                                   : r_scratch[4*d +: 4];
        end
    endgenerate

    // Top digit's carry is dropped: oversize values truncate silently.
    assign w_next_scratch = {w_adj[c_BCD_W-2:0], r_shift[W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_bcd_out <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.bin_in;
                        r_scratch <= '0;
                        r_cnt     <= c_CNT_LOAD;
                        r_state   <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= {r_shift[W-2:0], 1'b0};
                    r_cnt     <= r_cnt - c_CNT_ONE;
                    // Last bit: publish the result on the same edge.
                    if (r_cnt == c_CNT_ONE) begin
                        r_bcd_out <= w_next_scratch;
                        r_done    <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state == c_SHIFT);
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd_out;

endmodule
`default_nettype wire
